// File: rtl/t05_fetch_pkg.sv
// Shared types and constants for the t05 instruction fetch stage.
package t05_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Clear the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/t05_instruction_fetch_if.sv
// Memory-request and decode-handoff signals of the fetch stage.
// master: the fetch stage. slave: memory handler plus decode unit.
interface t05_instruction_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instruction, pc_out, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instruction, pc_out, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );

endinterface

// File: rtl/t05_fetch_timer.sv
// Saturating wait counter for the fetch stage. o_expired pulses while
// enabled and the count has reached LIMIT-1 (LIMIT in 1..65535).
module t05_fetch_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] r_count;

  // Count enabled cycles, holding at LAST; clear has priority.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/t05_instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues one read at a time over
// req/ack, hands the word to decode over valid/ready, and follows
// redirects from execute. Optional build macro T05_FETCH_MISALIGN_TRAP_EN
// adds a sticky misalign_err output and traps misaligned redirect targets.
module t05_instruction_fetch
  import t05_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_load_pc,
  input  logic [31:0]             i_pc_target,
  t05_instruction_fetch_if.master bus,
  output logic                    o_fetch_err
`ifdef T05_FETCH_MISALIGN_TRAP_EN
  ,
  output logic                    o_misalign_err
`endif
);

  fetch_state_t r_state, w_state_next;

  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic [31:0] r_instruction, w_instruction_next;
  logic [31:0] r_pc_out, w_pc_out_next;
  logic [31:0] r_target, w_target_next;
  logic        r_mem_req, w_mem_req_next;
  logic        r_instr_valid, w_instr_valid_next;
  logic        r_fetch_err, w_fetch_err_next;
  logic        r_flush, w_flush_next;

  logic        w_timer_clear;
  logic        w_timer_en;
  logic        w_timer_expired;
  logic [31:0] w_target_in;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_inc;
  logic        w_target_bad;
  logic        w_trap_pending;

`ifdef T05_FETCH_MISALIGN_TRAP_EN
  logic r_misalign_err;
  logic r_misalign_pend;
  logic w_misalign_set;

  assign w_target_in    = i_pc_target;
  assign w_target_bad   = |i_pc_target[1:0];
  assign w_trap_pending = r_misalign_pend;
  assign w_misalign_set = i_load_pc && w_target_bad && ((r_state == WAIT) || (r_state == VALID));
`else
  assign w_target_in    = align_pc(i_pc_target);
  assign w_target_bad   = 1'b0;
  assign w_trap_pending = 1'b0;
`endif

  assign w_pc_inc = r_pc + PC_STEP;

  t05_fetch_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_timer_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-datapath decisions for every FSM state.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_mem_addr_next    = r_mem_addr;
    w_instruction_next = r_instruction;
    w_pc_out_next      = r_pc_out;
    w_target_next      = r_target;
    w_mem_req_next     = r_mem_req;
    w_instr_valid_next = r_instr_valid;
    w_fetch_err_next   = r_fetch_err;
    w_flush_next       = r_flush;
    w_timer_clear      = 1'b1;
    w_timer_en         = 1'b0;
    // A redirect seen with the ack wins over one latched earlier.
    w_redirect_pc      = i_load_pc ? w_target_in : r_target;

    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_next    = WAIT;
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_pc;
        end
      end

      WAIT: begin
        w_timer_clear = bus.mem_ack;
        w_timer_en    = ~bus.mem_ack;
        if (bus.mem_ack) begin
          if (w_trap_pending || (i_load_pc && w_target_bad)) begin
            w_state_next     = ERROR;
            w_mem_req_next   = 1'b0;
            w_fetch_err_next = 1'b1;
          end else if (r_flush || i_load_pc) begin
            // Stale word: drop it and re-issue at the redirect target.
            w_pc_next       = w_redirect_pc;
            w_mem_addr_next = w_redirect_pc;
            w_flush_next    = 1'b0;
          end else begin
            w_instruction_next = bus.mem_rdata;
            w_pc_out_next      = r_pc;
            w_instr_valid_next = 1'b1;
            w_mem_req_next     = 1'b0;
            w_state_next       = VALID;
          end
        end else if (w_timer_expired) begin
          w_state_next     = ERROR;
          w_mem_req_next   = 1'b0;
          w_fetch_err_next = 1'b1;
        end else if (i_load_pc) begin
          // Address must stay put until the outstanding read completes.
          w_target_next = w_target_in;
          w_flush_next  = 1'b1;
        end
      end

      VALID: begin
        if (i_load_pc) begin
          w_instr_valid_next = 1'b0;
          if (w_target_bad) begin
            w_state_next     = ERROR;
            w_fetch_err_next = 1'b1;
          end else begin
            w_pc_next       = w_target_in;
            w_state_next    = WAIT;
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = w_target_in;
          end
        end else if (bus.instr_ready) begin
          w_pc_next          = w_pc_inc;
          w_instr_valid_next = 1'b0;
          if (i_en) begin
            w_state_next    = WAIT;
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = w_pc_inc;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      ERROR: begin
        w_mem_req_next     = 1'b0;
        w_instr_valid_next = 1'b0;
        w_fetch_err_next   = 1'b1;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: PC, request, decode handoff and redirect bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_mem_addr    <= RESET_PC;
      r_instruction <= NOP_INSTR;
      r_pc_out      <= RESET_PC;
      r_target      <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_mem_addr    <= w_mem_addr_next;
      r_instruction <= w_instruction_next;
      r_pc_out      <= w_pc_out_next;
      r_target      <= w_target_next;
      r_mem_req     <= w_mem_req_next;
      r_instr_valid <= w_instr_valid_next;
      r_fetch_err   <= w_fetch_err_next;
      r_flush       <= w_flush_next;
    end
  end

`ifdef T05_FETCH_MISALIGN_TRAP_EN
  // Sticky misalign flag; a trap raised in WAIT waits for the ack to drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err  <= 1'b0;
      r_misalign_pend <= 1'b0;
    end else begin
      if (w_misalign_set) begin
        r_misalign_err <= 1'b1;
      end
      if (w_misalign_set && (r_state == WAIT) && !bus.mem_ack) begin
        r_misalign_pend <= 1'b1;
      end
    end
  end

  assign o_misalign_err = r_misalign_err;
`endif

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instruction = r_instruction;
  assign bus.pc_out      = r_pc_out;
  assign bus.instr_valid = r_instr_valid;
  assign o_fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_t05_instruction_fetch.sv
// Self-checking bench for t05_instruction_fetch: directed scenarios plus a
// randomized run against a program-order model of the delivered stream.
module tb_t05_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_pc;
  logic [31:0] pc_target;
  logic        fetch_err;
`ifdef T05_FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  // Memory responder controls.
  bit mem_mute = 1'b0;
  bit mem_rand = 1'b0;
  int mem_lat  = 1;
  int mem_cnt  = 0;

  t05_instruction_fetch_if bus ();

  t05_instruction_fetch #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_load_pc      (load_pc),
    .i_pc_target    (pc_target),
    .bus            (bus),
    .o_fetch_err    (fetch_err)
`ifdef T05_FETCH_MISALIGN_TRAP_EN
    ,
    .o_misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Program image: address 0 holds addi x1,x0,5; elsewhere a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  // Memory handler: acks a held request after mem_lat idle cycles.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || mem_mute || (bus.mem_req !== 1'b1)) begin
        bus.mem_ack = 1'b0;
        mem_cnt     = 0;
      end else if (mem_cnt >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        mem_cnt       = 0;
        if (mem_rand) mem_lat = $urandom_range(0, 2);
      end else begin
        bus.mem_ack = 1'b0;
        mem_cnt++;
      end
    end
  end

  task automatic wait_valid(input string what);
    int n = 0;
    while ((bus.instr_valid !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_valid: instr_valid=%b after %0d cycles, want 1", what, bus.instr_valid, n);
    end
  endtask

  task automatic consume();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.instruction !== 32'h0000_0013) begin errors++; $display("FAIL reset_instruction: got %h want 00000013", bus.instruction); end
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", bus.pc_out); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
`ifdef T05_FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign_err: got %b want 0", misalign_err); end
`endif
  endtask

  task automatic test_basic_fetch();
    en  = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 0", bus.mem_addr); end
    wait_valid("basic");
    checks++; if (bus.instruction !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h want 00500093", bus.instruction); end
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL basic_pc_out: got %h want 0", bus.pc_out); end
    consume();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.instr_valid); end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr: req=%b addr=%h want 1/4", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_stall();
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    wait_valid("stall");
    held_instr = bus.instruction;
    held_pc    = bus.pc_out;
    checks++; if (held_pc !== 32'h4 || held_instr !== mem_word(32'h4)) begin errors++; $display("FAIL stall_first: pc=%h instr=%h want 4/%h", held_pc, held_instr, mem_word(32'h4)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruction !== held_instr || bus.pc_out !== held_pc || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h req=%b want 1/%h/%h/0", i, bus.instr_valid, bus.instruction, bus.pc_out, bus.mem_req, held_instr, held_pc);
      end
    end
    consume();
  endtask

  task automatic test_redirect_wait();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL redir_pre: req=%b addr=%h want 1/8", bus.mem_req, bus.mem_addr); end
    load_pc   = 1'b1;
    pc_target = 32'h100;
    @(negedge clk);
    load_pc = 1'b0;
    checks++; if (bus.mem_addr !== 32'h8) begin errors++; $display("FAIL redir_addr_stable: got %h want 8", bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_reissue: req=%b addr=%h valid=%b want 1/100/0", bus.mem_req, bus.mem_addr, bus.instr_valid); end
    wait_valid("redir");
    checks++; if (bus.pc_out !== 32'h100 || bus.instruction !== mem_word(32'h100)) begin errors++; $display("FAIL redir_deliver: pc=%h instr=%h want 100/%h", bus.pc_out, bus.instruction, mem_word(32'h100)); end
  endtask

  task automatic test_load_and_ready();
    load_pc         = 1'b1;
    pc_target       = 32'h40;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    load_pc         = 1'b0;
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin errors++; $display("FAIL ldrdy_addr: valid=%b req=%b addr=%h want 0/1/40", bus.instr_valid, bus.mem_req, bus.mem_addr); end
    wait_valid("ldrdy");
    checks++; if (bus.pc_out !== 32'h40) begin errors++; $display("FAIL ldrdy_pc_out: got %h want 40", bus.pc_out); end
    consume();
    checks++; if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL ldrdy_next: got %h want 44", bus.mem_addr); end
  endtask

  task automatic test_misalign();
    wait_valid("misalign");
    load_pc   = 1'b1;
    pc_target = 32'h102;
    @(negedge clk);
    load_pc = 1'b0;
`ifdef T05_FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b1 || fetch_err !== 1'b1) begin errors++; $display("FAIL misalign_flag: misalign_err=%b fetch_err=%b want 1/1", misalign_err, fetch_err); end
    checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_halt: req=%b valid=%b want 0/0", bus.mem_req, bus.instr_valid); end
`else
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL misalign_clear: req=%b addr=%h want 1/100", bus.mem_req, bus.mem_addr); end
    wait_valid("misalign");
    checks++; if (bus.pc_out !== 32'h100) begin errors++; $display("FAIL misalign_pc_out: got %h want 100", bus.pc_out); end
`endif
  endtask

  task automatic test_idle_en_and_wrap();
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_valid("idle");
    en = 1'b0;
    consume();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_hold%0d: req=%b valid=%b want 0/0", i, bus.mem_req, bus.instr_valid); end
      @(negedge clk);
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL idle_resume: req=%b addr=%h want 1/4", bus.mem_req, bus.mem_addr); end
    wait_valid("wrap");
    load_pc   = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    @(negedge clk);
    load_pc = 1'b0;
    wait_valid("wrap");
    checks++; if (bus.pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_out: got %h want fffffffc", bus.pc_out); end
    consume();
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 0", bus.mem_addr); end
  endtask

  // Model: decode sees consecutive words; any redirect restarts the stream at
  // its (word-aligned) target, and an instruction presented with a redirect is dropped.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          rdy;
    bit          ld;
    int          consumed;
    rst      = 1'b1;
    en       = 1'b1;
    mem_rand = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_pc   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 9) < 7);
      ld  = ((bus.mem_req === 1'b1) || (bus.instr_valid === 1'b1)) && ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
`ifdef T05_FETCH_MISALIGN_TRAP_EN
      tgt = tgt & ~32'd3;
`endif
      if (bus.instr_valid === 1'b1) begin
        checks++;
        if (bus.pc_out !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_deliver@%0d: pc=%h instr=%h want %h/%h", c, bus.pc_out, bus.instruction, exp_pc, mem_word(exp_pc));
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rand_req_in_valid@%0d: got %b want 0", c, bus.mem_req); end
      end
      checks++;
      if (fetch_err !== 1'b0) begin errors++; $display("FAIL rand_fetch_err@%0d: got %b want 0", c, fetch_err); end
      if (ld) begin
        exp_pc = tgt & ~32'd3;
      end else if ((bus.instr_valid === 1'b1) && rdy) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      bus.instr_ready = rdy;
      load_pc         = ld;
      pc_target       = tgt;
    end
    bus.instr_ready = 1'b0;
    load_pc         = 1'b0;
    mem_rand        = 1'b0;
    mem_lat         = 1;
    checks++;
    if (consumed < 100) begin errors++; $display("FAIL rand_throughput: consumed %0d want >=100", consumed); end
  endtask

  task automatic test_timeout();
    int n_wait = 0;
    rst      = 1'b1;
    en       = 1'b1;
    mem_mute = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_err === 1'b1) break;
      if (bus.mem_req === 1'b1) n_wait++;
    end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", fetch_err); end
    checks++; if (n_wait != 4) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 4", n_wait); end
    checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL timeout_halt: req=%b valid=%b want 0/0", bus.mem_req, bus.instr_valid); end
    repeat (3) @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_sticky: err=%b req=%b want 1/0", fetch_err, bus.mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (fetch_err !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_rst_clear: err=%b req=%b want 0/0", fetch_err, bus.mem_req); end
    mem_mute = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    en              = 1'b0;
    load_pc         = 1'b0;
    pc_target       = '0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_load_and_ready();
    test_misalign();
    test_idle_en_and_wrap();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
